// File: rtl/alu_pkg.sv
// Shared types for the round-robin adder arbiter.
// Holds default widths, FSM state and requester ID types.
package alu_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNTW_DEF  = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker.
// Ports: valid0/valid1 requests, last = previous winner, grant one-hot.
module rr_pick2
    import alu_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  req_id_t    last,
    output logic [1:0] grant
);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant    = 2'b00;
        grant[0] = valid0 & (~valid1 | last);
        grant[1] = valid1 & (~valid0 | ~last);
    end

endmodule

// File: rtl/alu_rr_arb.sv
// Two requesters share one registered adder, arbitrated round-robin.
// Ports: i_A*/i_B*/i_VALID*/o_READY* requests, o_Y/o_C/o_ID/o_VALID/i_READY result, o_CNT* per-ID totals.
module alu_rr_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic [WIDTH-1:0] i_A0,
    input  logic [WIDTH-1:0] i_B0,
    input  logic             i_VALID0,
    output logic             o_READY0,
    input  logic [WIDTH-1:0] i_A1,
    input  logic [WIDTH-1:0] i_B1,
    input  logic             i_VALID1,
    output logic             o_READY1,
    output logic [WIDTH-1:0] o_Y,
    output logic             o_C,
    output logic             o_ID,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic [CNTW-1:0]  o_CNT0,
    output logic [CNTW-1:0]  o_CNT1
);

    state_t           state;
    req_id_t          last;
    logic [1:0]       grant;
    logic             slot_free;
    logic             accept;
    logic             drain;
    req_id_t          pick_id;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH:0]   sum;

    rr_pick2 u_pick (
        .valid0 (i_VALID0),
        .valid1 (i_VALID1),
        .last   (last),
        .grant  (grant)
    );

    // A full slot counts as free when the consumer drains it this edge.
    assign slot_free = (state == EMPTY) | i_READY;

    // Reset gating keeps both requesters stalled while reset is held.
    assign o_READY0 = i_RSTn & slot_free & grant[0];
    assign o_READY1 = i_RSTn & slot_free & grant[1];

    assign accept  = (o_READY0 & i_VALID0) | (o_READY1 & i_VALID1);
    assign drain   = (state == FULL) & i_READY;
    assign pick_id = grant[1];
    assign o_VALID = (state == FULL);

    assign sel_a = pick_id ? i_A1 : i_A0;
    assign sel_b = pick_id ? i_B1 : i_B0;
    assign sum   = {1'b0, sel_a} + {1'b0, sel_b};

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state  <= EMPTY;
            o_Y    <= '0;
            o_C    <= 1'b0;
            o_ID   <= 1'b0;
            last   <= 1'b1;
            o_CNT0 <= '0;
            o_CNT1 <= '0;
        end else begin
            if (drain) begin
                if (o_ID)
                    o_CNT1 <= o_CNT1 + CNTW'(1);
                else
                    o_CNT0 <= o_CNT0 + CNTW'(1);
            end
            if (accept) begin
                {o_C, o_Y} <= sum;
                o_ID       <= pick_id;
                last       <= pick_id;
                state      <= FULL;
            end else if (drain) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arb.sv
// Scoreboard bench for alu_rr_arb.
// Directed vectors push expected results; a monitor pops on each output transfer.
module tb_alu_rr_arb;

    localparam int W = 4;
    localparam int CW = 8;

    typedef struct {
        logic         id;
        logic [W-1:0] y;
        logic         c;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  a0, b0, a1, b1;
    logic          v0, v1;
    logic          rdy0, rdy1;
    logic [W-1:0]  y;
    logic          c;
    logic          id;
    logic          ov;
    logic          ir;
    logic [CW-1:0] cnt0, cnt1;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    alu_rr_arb #(.WIDTH(W), .CNTW(CW)) dut (
        .i_CLK    (clk),
        .i_RSTn   (rst_n),
        .i_A0     (a0),
        .i_B0     (b0),
        .i_VALID0 (v0),
        .o_READY0 (rdy0),
        .i_A1     (a1),
        .i_B1     (b1),
        .i_VALID1 (v1),
        .o_READY1 (rdy1),
        .o_Y      (y),
        .o_C      (c),
        .o_ID     (id),
        .o_VALID  (ov),
        .i_READY  (ir),
        .o_CNT0   (cnt0),
        .o_CNT1   (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic pid, input int py, input logic pc);
        exp_t e;
        e.id = pid;
        e.y  = W'(py);
        e.c  = pc;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ov && ir) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res_id", int'(id), int'(e.id));
                chk("res_y", int'(y), int'(e.y));
                chk("res_c", int'(c), int'(e.c));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        {a0, b0, a1, b1} = '0;
        v0 = 1'b1;
        v1 = 1'b1;
        ir = 1'b1;
        @(negedge clk);
        chk("rst_rdy0", int'(rdy0), 0);
        chk("rst_rdy1", int'(rdy1), 0);
        chk("rst_valid", int'(ov), 0);
        chk("rst_cnt0", int'(cnt0), 0);
        chk("rst_cnt1", int'(cnt1), 0);
        v0 = 1'b0;
        v1 = 1'b0;
        step();
        rst_n = 1'b1;

        // Alternating grants under continuous contention.
        a0 = 1; b0 = 1; a1 = 2; b1 = 2;
        push(0, 2, 0); push(1, 4, 0); push(0, 2, 0); push(1, 4, 0);
        v0 = 1'b1; v1 = 1'b1; ir = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_rdy0", int'(rdy0), (k % 2 == 0) ? 1 : 0);
            chk("alt_rdy1", int'(rdy1), (k % 2 == 0) ? 0 : 1);
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("alt_cnt0", int'(cnt0), 2);
        chk("alt_cnt1", int'(cnt1), 2);
        chk("alt_idle", int'(ov), 0);
        step();

        // Single requester, 3+4.
        a0 = 3; b0 = 4;
        push(0, 7, 0);
        v0 = 1'b1;
        @(negedge clk);
        chk("one_rdy0", int'(rdy0), 1);
        chk("one_rdy1", int'(rdy1), 0);
        step();
        v0 = 1'b0;
        @(negedge clk);
        chk("one_valid", int'(ov), 1);
        step();
        @(negedge clk);
        chk("one_cnt0", int'(cnt0), 3);
        chk("one_idle", int'(ov), 0);
        step();

        // Back-pressure: 9+8 from requester 1 held, 5+6 waiting on 0.
        a1 = 9; b1 = 8; a0 = 5; b0 = 6;
        v0 = 1'b1; v1 = 1'b1; ir = 1'b0;
        push(1, 1, 1);
        @(negedge clk);
        chk("bp_rdy1", int'(rdy1), 1);
        chk("bp_rdy0", int'(rdy0), 0);
        step();
        v1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(ov), 1);
            chk("bp_hold_y", int'(y), 1);
            chk("bp_hold_c", int'(c), 1);
            chk("bp_hold_id", int'(id), 1);
            chk("bp_hold_rdy0", int'(rdy0), 0);
            chk("bp_hold_rdy1", int'(rdy1), 0);
            step();
        end
        ir = 1'b1;
        push(0, 11, 0);
        @(negedge clk);
        chk("bp_refill_rdy0", int'(rdy0), 1);
        step();
        v0 = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("bp_cnt0", int'(cnt0), 4);
        chk("bp_cnt1", int'(cnt1), 3);
        step();

        // Async reset while a result is held.
        a0 = 1; b0 = 2; v0 = 1'b1; ir = 1'b0;
        @(negedge clk);
        chk("ar_rdy0", int'(rdy0), 1);
        step();
        v0 = 1'b0;
        @(negedge clk);
        chk("ar_full", int'(ov), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", int'(ov), 0);
        chk("ar_y", int'(y), 0);
        chk("ar_cnt0", int'(cnt0), 0);
        chk("ar_cnt1", int'(cnt1), 0);
        chk("ar_rdy0_low", int'(rdy0), 0);
        step();
        rst_n = 1'b1;
        a0 = 1; b0 = 1; a1 = 2; b1 = 2;
        v0 = 1'b1; v1 = 1'b1; ir = 1'b1;
        push(0, 2, 0);
        @(negedge clk);
        chk("ar_tie_rdy0", int'(rdy0), 1);
        chk("ar_tie_rdy1", int'(rdy1), 0);
        step();
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("ar_post_cnt0", int'(cnt0), 1);
        chk("ar_post_idle", int'(ov), 0);
        step();

        // Counter wrap: 256 results from requester 0.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        a0 = 15; b0 = 15;
        for (int k = 0; k < 256; k++) push(0, 14, 1);
        v0 = 1'b1;
        for (int k = 0; k < 256; k++) step();
        v0 = 1'b0;
        @(negedge clk);
        chk("wrap_cnt0_255", int'(cnt0), 255);
        chk("wrap_last_valid", int'(ov), 1);
        step();
        @(negedge clk);
        chk("wrap_cnt0", int'(cnt0), 0);
        chk("wrap_cnt1", int'(cnt1), 0);
        chk("wrap_idle", int'(ov), 0);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_rr_arb.md
ALU_RR_ARB -- requirements
Module: alu_rr_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width.
REQ-002 SHALL have parameter CNTW, default 8, width of per-requester completion counters.
REQ-003 i_CLK  in  1  single clock; all state on rising edge.
REQ-004 i_RSTn  in  1  reset, asynchronous, active-low.
REQ-005 i_A0, i_B0  in  WIDTH each  requester 0 operands.
REQ-006 i_VALID0  in  1 / o_READY0  out  1  requester 0 handshake.
REQ-007 i_A1, i_B1  in  WIDTH each  requester 1 operands.
REQ-008 i_VALID1  in  1 / o_READY1  out  1  requester 1 handshake.
REQ-009 o_Y  out  WIDTH  registered sum of granted operands, mod 2^WIDTH.
REQ-010 o_C  out  1  registered carry-out of that sum.
REQ-011 o_ID  out  1  requester that owns o_Y (0 or 1).
REQ-012 o_VALID  out  1 / i_READY  in  1  result handshake to consumer.
REQ-013 o_CNT0, o_CNT1  out  CNTW each  results delivered per requester.

Function
REQ-014 Transfer on any port SHALL occur only on a clock edge where VALID and READY are both 1.
REQ-015 FSM SHALL have two states: EMPTY (no held result) and FULL (result held, o_VALID=1).
REQ-016 Slot "free" SHALL mean state EMPTY, or state FULL with i_READY=1 (same-cycle drain and refill).
REQ-017 o_READYx SHALL be 1 only when slot is free and requester x is the current pick; at most one o_READYx high per cycle.
REQ-018 Pick: if only one i_VALIDx high, pick it; if both high, pick the requester not granted last (round-robin pointer LAST).
REQ-019 On acceptance from x: register {o_C,o_Y} = i_Ax + i_Bx computed at WIDTH+1 bits, o_ID = x, LAST = x, state -> FULL; latency 1 cycle, valid the next edge.
REQ-020 FULL with i_READY=1 and no acceptance SHALL go to EMPTY; FULL with i_READY=0 SHALL hold o_Y, o_C, o_ID stable.
REQ-021 o_READYx SHALL depend combinationally on i_VALID0/1, i_READY, state and LAST only; never on operand values.
REQ-022 On each output transfer, o_CNT[o_ID] SHALL increment by 1, wrapping to 0 after 2^CNTW-1.
REQ-023 Simultaneous drain and accept SHALL both count: counter of drained ID increments and new result loads in same edge.
REQ-024 LAST SHALL change only on acceptance; idle cycles and drain-only cycles leave it unchanged.
REQ-025 Neither requester SHALL wait more than one acceptance while the other is also valid (no starvation).

Reset
REQ-026 i_RSTn=0 SHALL immediately, without clock, force state EMPTY, o_VALID=0, o_Y=0, o_C=0, o_ID=0, LAST=1 (so requester 0 wins first tie), o_CNT0=o_CNT1=0.
REQ-027 While i_RSTn=0, o_READY0 and o_READY1 SHALL be 0.
REQ-028 Reset asserted mid-transfer SHALL discard the held result with no counter update; first acceptance is allowed on the first edge after deassertion.

Structure
REQ-029 Shared package alu_pkg SHALL hold: WIDTH default, FSM state typedef (EMPTY, FULL), requester-ID typedef (1 bit).
REQ-030 Round-robin selection SHALL be a sub-module rr_pick2 (inputs: two valids, LAST; outputs: one-hot grant); adder and result register stay in alu_rr_arb.

Verification
REQ-031 Reset, then A0=3,B0=4,V0=1, V1=0, i_READY=1 -> READY0=1 that cycle; next cycle o_Y=7, o_C=0, o_ID=0, o_VALID=1; o_CNT0=1 one cycle after drain.
REQ-032 Both valid continuously, A0=1,B0=1, A1=2,B1=2, i_READY=1 -> grants alternate 0,1,0,1; o_Y sequence 2,4,2,4; one result per cycle.
REQ-033 A1=9,B1=8 accepted, i_READY=0 for 3 cycles -> o_Y=1, o_C=1, o_ID=1 stable, o_READY0=o_READY1=0; i_READY=1 -> drains, new request accepted same edge.
REQ-034 Drive 256 requester-0 results with CNTW=8 -> o_CNT0 wraps to 0, o_CNT1 stays 0.
REQ-035 Assert i_RSTn=0 while FULL and mid-clock-period -> o_VALID drops before next edge, counters 0, next tie goes to requester 0.
